ov7670_capture: RTL and testbench

OV7670_CAPTURE -- requirements
Module: ov7670_capture

---
 rtl/ov7670_capture.sv | 132 +++++++++++++
 tb/tb_ov7670_capture.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture.sv
// OV7670 camera capture: synchronizes the camera bus into the clk domain,
// assembles RGB565 pixels and streams them as frame-buffer writes.
module ov7670_capture #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              busy
);

  localparam int COL_W  = $clog2(H_PIXELS + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);
  localparam logic [COL_W-1:0]  COL_MAX    = COL_W'(H_PIXELS);
  localparam logic [LINE_W-1:0] LINE_MAX   = LINE_W'(V_LINES);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(H_PIXELS * V_LINES);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;

  state_t            state;
  logic [2:0]        pclk_sr, vsync_sr, href_sr;
  logic [7:0]        data_s1, data_s2;
  logic [7:0]        hi_byte;
  logic              phase;
  logic              line_has_pix;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line;
  logic [ADDR_W-1:0] addr_cnt;

  // Stage [1] is the second synchronizer flop; stage [2] only serves edge detection.
  logic pe, vf, vr, hf;
  assign pe   = pclk_sr[1] & ~pclk_sr[2];
  assign vf   = vsync_sr[2] & ~vsync_sr[1];
  assign vr   = ~vsync_sr[2] & vsync_sr[1];
  assign hf   = href_sr[2] & ~href_sr[1];
  assign busy = (state == CAPTURE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pclk_sr      <= '0;
      vsync_sr     <= '0;
      href_sr      <= '0;
      data_s1      <= '0;
      data_s2      <= '0;
      hi_byte      <= '0;
      phase        <= 1'b0;
      line_has_pix <= 1'b0;
      col          <= '0;
      line         <= '0;
      addr_cnt     <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= 16'h0000;
      frame_done   <= 1'b0;
    end else begin
      pclk_sr    <= {pclk_sr[1:0], cam_pclk};
      vsync_sr   <= {vsync_sr[1:0], cam_vsync};
      href_sr    <= {href_sr[1:0], cam_href};
      data_s1    <= cam_data;
      data_s2    <= data_s1;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (capture_en) state <= WAIT_FRAME;
        end

        WAIT_FRAME: begin
          if (!capture_en) begin
            state <= IDLE;
          end else if (vf) begin
            state        <= CAPTURE;
            col          <= '0;
            line         <= '0;
            addr_cnt     <= '0;
            phase        <= 1'b0;
            line_has_pix <= 1'b0;
          end
        end

        CAPTURE: begin
          if (vr) begin
            frame_done <= 1'b1;
            state      <= capture_en ? WAIT_FRAME : IDLE;
          end else if (vf) begin
            // Missed the end of the previous frame: silently start over.
            col          <= '0;
            line         <= '0;
            addr_cnt     <= '0;
            phase        <= 1'b0;
            line_has_pix <= 1'b0;
          end else if (hf) begin
            col          <= '0;
            phase        <= 1'b0;
            line_has_pix <= 1'b0;
            if (line_has_pix && line < LINE_MAX) line <= line + LINE_W'(1);
          end else if (pe && href_sr[1]) begin
            if (!phase) begin
              hi_byte <= data_s2;
              phase   <= 1'b1;
            end else begin
              phase        <= 1'b0;
              line_has_pix <= 1'b1;
              if (col < COL_MAX && line < LINE_MAX && addr_cnt < ADDR_LIMIT) begin
                wr_en    <= 1'b1;
                wr_addr  <= addr_cnt;
                wr_data  <= {hi_byte, data_s2};
                addr_cnt <= addr_cnt + ADDR_W'(1);
              end
              if (col < COL_MAX) col <= col + COL_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture on a reduced 8x6 frame: a camera model drives the
// byte bus and a scoreboard queue holds every write the frame buffer should see.
module tb_ov7670_capture;

  localparam int H = 8;
  localparam int V = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        capture_en = 1'b0;
  logic        cam_pclk = 1'b0;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic        frame_done;
  logic        busy;

  typedef struct {
    logic [16:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  lb[$];
  int          total = 0;
  int          bad = 0;
  int          fd_count = 0;
  int          n_writes = 0;
  logic [16:0] last_addr = '0;
  int          m_line = 0;
  logic [16:0] m_addr = '0;

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(17)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Every write strobe is checked against the oldest expected write.
  always @(negedge clk) begin
    if (frame_done) fd_count++;
    if (wr_en) begin
      exp_t e;
      n_writes++;
      last_addr = wr_addr;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_write addr=%0d data=%h required=no write", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          bad++;
          $display("[TB] FAIL write got addr=%0d data=%h required addr=%0d data=%h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // pclk period = 4 clk cycles (25 MHz); data changes while pclk is low.
  task automatic send_byte(input logic [7:0] b);
    cam_data = b;
    cam_pclk = 1'b0;
    tick(2);
    cam_pclk = 1'b1;
    tick(2);
  endtask

  task automatic idle_pclk(input int n);
    for (int i = 0; i < n; i++) send_byte(8'h00);
  endtask

  task automatic fill_line(input int idx, input int nbytes);
    lb.delete();
    for (int i = 0; i < nbytes; i++) lb.push_back(8'(idx * 29 + i * 7 + 3));
  endtask

  task automatic send_line(input bit expect_w);
    int npix;
    exp_t e;
    npix = lb.size() / 2;
    for (int p = 0; p < npix; p++) begin
      if (expect_w && p < H && m_line < V) begin
        e.addr = m_addr;
        e.data = {lb[2*p], lb[2*p+1]};
        sb.push_back(e);
        m_addr = m_addr + 17'd1;
      end
    end
    if (npix > 0 && m_line < V) m_line++;
    cam_href = 1'b1;
    foreach (lb[i]) send_byte(lb[i]);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    tick(2);
    idle_pclk(3);
  endtask

  task automatic start_frame();
    cam_vsync = 1'b1;
    idle_pclk(2);
    m_line   = 0;
    m_addr   = '0;
    n_writes = 0;
    cam_vsync = 1'b0;
    idle_pclk(2);
  endtask

  task automatic end_frame();
    cam_vsync = 1'b1;
    idle_pclk(3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    capture_en = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    total += 5;
    if (wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_en got=%b required=0", wr_en); end
    if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_done got=%b required=0", frame_done); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b required=0", busy); end
    if (wr_addr !== 17'd0) begin bad++; $display("[TB] FAIL reset_wr_addr got=%0d required=0", wr_addr); end
    if (wr_data !== 16'h0000) begin bad++; $display("[TB] FAIL reset_wr_data got=%h required=0000", wr_data); end
  endtask

  task automatic test_full_frame();
    int fd0;
    capture_en = 1'b1;
    tick(3);
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL wait_busy got=%b required=0", busy); end
    start_frame();
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL capture_busy got=%b required=1", busy); end
    for (int l = 0; l <= V; l++) begin
      fill_line(l, 2 * H);
      send_line(1'b1);
    end
    fd0 = fd_count;
    end_frame();
    total += 5;
    if (fd_count !== fd0 + 1) begin bad++; $display("[TB] FAIL full_frame_done got=%0d required=%0d", fd_count - fd0, 1); end
    if (n_writes !== H * V) begin bad++; $display("[TB] FAIL full_writes got=%0d required=%0d", n_writes, H * V); end
    if (last_addr !== 17'(H * V - 1)) begin bad++; $display("[TB] FAIL full_last_addr got=%0d required=%0d", last_addr, H * V - 1); end
    if (sb.size() !== 0) begin bad++; $display("[TB] FAIL full_pending got=%0d required=0", sb.size()); sb.delete(); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL full_busy_after got=%b required=0", busy); end
  endtask

  task automatic test_pixel_bytes();
    start_frame();
    lb.delete();
    lb.push_back(8'hA5); lb.push_back(8'h5A); lb.push_back(8'h12); lb.push_back(8'h34);
    send_line(1'b1);
    total += 3;
    if (n_writes !== 2) begin bad++; $display("[TB] FAIL bytes_writes got=%0d required=2", n_writes); end
    if (last_addr !== 17'd1) begin bad++; $display("[TB] FAIL bytes_last_addr got=%0d required=1", last_addr); end
    if (sb.size() !== 0) begin bad++; $display("[TB] FAIL bytes_pending got=%0d required=0", sb.size()); sb.delete(); end
    end_frame();
  endtask

  task automatic test_long_odd_lines();
    start_frame();
    fill_line(0, 2 * H + 4);
    send_line(1'b1);
    fill_line(1, 2 * H + 1);
    send_line(1'b1);
    fill_line(2, 2 * H);
    send_line(1'b1);
    total += 3;
    if (n_writes !== 3 * H) begin bad++; $display("[TB] FAIL long_odd_writes got=%0d required=%0d", n_writes, 3 * H); end
    if (last_addr !== 17'(3 * H - 1)) begin bad++; $display("[TB] FAIL long_odd_last got=%0d required=%0d", last_addr, 3 * H - 1); end
    if (sb.size() !== 0) begin bad++; $display("[TB] FAIL long_odd_pending got=%0d required=0", sb.size()); sb.delete(); end
    end_frame();
  endtask

  task automatic test_capture_drop();
    int fd0;
    capture_en = 1'b1;
    start_frame();
    fd0 = fd_count;
    for (int l = 0; l < V; l++) begin
      if (l == 3) capture_en = 1'b0;
      fill_line(l + 10, 2 * H);
      send_line(1'b1);
    end
    end_frame();
    total += 4;
    if (fd_count !== fd0 + 1) begin bad++; $display("[TB] FAIL drop_frame_done got=%0d required=1", fd_count - fd0); end
    if (n_writes !== H * V) begin bad++; $display("[TB] FAIL drop_writes got=%0d required=%0d", n_writes, H * V); end
    if (last_addr !== 17'(H * V - 1)) begin bad++; $display("[TB] FAIL drop_last_addr got=%0d required=%0d", last_addr, H * V - 1); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL drop_busy got=%b required=0", busy); end
    fd0 = fd_count;
    start_frame();
    for (int l = 0; l < 2; l++) begin
      fill_line(l, 2 * H);
      send_line(1'b0);
    end
    end_frame();
    total += 2;
    if (n_writes !== 0) begin bad++; $display("[TB] FAIL idle_writes got=%0d required=0", n_writes); end
    if (fd_count !== fd0) begin bad++; $display("[TB] FAIL idle_frame_done got=%0d required=0", fd_count - fd0); end
  endtask

  task automatic test_reset_mid();
    int fd0;
    capture_en = 1'b1;
    tick(2);
    start_frame();
    for (int l = 0; l < 3; l++) begin
      fill_line(l + 40, 2 * H);
      send_line(1'b1);
    end
    fd0 = fd_count;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy got=%b required=0", busy); end
    if (n_writes !== 3 * H) begin bad++; $display("[TB] FAIL midreset_writes got=%0d required=%0d", n_writes, 3 * H); end
    for (int l = 0; l < 2; l++) begin
      fill_line(l + 50, 2 * H);
      send_line(1'b0);
    end
    end_frame();
    total += 2;
    if (fd_count !== fd0) begin bad++; $display("[TB] FAIL midreset_frame_done got=%0d required=0", fd_count - fd0); end
    if (n_writes !== 3 * H) begin bad++; $display("[TB] FAIL midreset_late_writes got=%0d required=%0d", n_writes, 3 * H); end
    start_frame();
    fill_line(60, 2 * H);
    send_line(1'b1);
    end_frame();
    total += 3;
    if (n_writes !== H) begin bad++; $display("[TB] FAIL restart_writes got=%0d required=%0d", n_writes, H); end
    if (fd_count !== fd0 + 1) begin bad++; $display("[TB] FAIL restart_frame_done got=%0d required=1", fd_count - fd0); end
    if (sb.size() !== 0) begin bad++; $display("[TB] FAIL restart_pending got=%0d required=0", sb.size()); sb.delete(); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_pixel_bytes();
    test_long_odd_lines();
    test_capture_drop();
    test_reset_mid();
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
